// File: rtl/lfsr32_pkg.sv
// Shared definitions for the 32-bit Galois LFSR generator/checker pair.
package lfsr32_pkg;

    localparam int unsigned LFSR_W    = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Right-shifting Galois step, taps 32,22,2,1: feedback bit q[0] folds into the tap mask.
    function automatic logic [LFSR_W-1:0] lfsr32_next(input logic [LFSR_W-1:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields one.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : W'(0);
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr32_checker.sv
// Self-synchronising checker for the 32-bit Galois LFSR word stream:
// seeds from the data, confirms LOCK_COUNT matches, then flywheels and counts errors.
module lfsr32_checker
    import lfsr32_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             err_clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             zero_seen,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

    chk_state_t         state_q;
    logic [31:0]        expected_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic               locked_q;
    logic               err_pulse_q;
    logic               zero_seen_q;

    logic               is_zero_c;
    logic               hit_c;
    logic [31:0]        seed_next_c;
    logic [31:0]        fly_next_c;
    logic [MATCH_W-1:0] match_inc_c;
    logic [MISS_W-1:0]  miss_inc_c;
    logic               err_inc_c;

    // Single-level compare and step logic shared by all states.
    always_comb begin
        is_zero_c   = (in_data == 32'h0);
        hit_c       = (in_data == expected_q);
        seed_next_c = lfsr32_next(in_data);
        fly_next_c  = lfsr32_next(expected_q);
        match_inc_c = match_cnt_q + MATCH_W'(1);
        miss_inc_c  = miss_cnt_q + MISS_W'(1);
        err_inc_c   = in_valid && (state_q == LOCKED) && !hit_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            zero_seen_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            zero_seen_q <= 1'b0;
            if (in_valid) begin
                zero_seen_q <= is_zero_c;
                unique case (state_q)
                    SEARCH: begin
                        if (!is_zero_c) begin
                            expected_q  <= seed_next_c;
                            match_cnt_q <= '0;
                            state_q     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (is_zero_c) begin
                            state_q <= SEARCH;
                        end else if (hit_c) begin
                            expected_q <= seed_next_c;
                            if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
                                match_cnt_q <= '0;
                                locked_q    <= 1'b1;
                                state_q     <= LOCKED;
                            end else begin
                                match_cnt_q <= match_inc_c;
                            end
                        end else begin
                            expected_q  <= seed_next_c;
                            match_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: received data never reseeds once locked.
                        expected_q <= fly_next_c;
                        if (hit_c) begin
                            miss_cnt_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (miss_inc_c == MISS_W'(LOSS_COUNT)) begin
                                miss_cnt_q <= '0;
                                locked_q   <= 1'b0;
                                state_q    <= SEARCH;
                            end else begin
                                miss_cnt_q <= miss_inc_c;
                            end
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc_c),
        .clr   (err_clear),
        .count (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign zero_seen = zero_seen_q;

endmodule
